// File: rtl/shifter_planar.sv
// shifter_planar: bitplane video shifter that collects one group of interleaved plane
// words and serialises them into colour indices. Optional fine scroll: SHIFTER_HSCROLL_EN.
module shifter_planar #(
   parameter int WORD_W     = 16,
   parameter int MAX_PLANES = 4,
   parameter int SC_W       = 4
) (
   input  logic                  clk32,
   input  logic                  nReset,
   input  logic                  pixClkEn,
   input  logic                  DE,
   input  logic                  LOAD,
   input  logic [1:0]            mode,
   input  logic [WORD_W-1:0]     DIN,
   input  logic [SC_W-1:0]       hscroll,
   output logic [MAX_PLANES-1:0] color_index,
   output logic                  pix_valid,
   output logic                  underrun
);
   localparam int PTR_W = (MAX_PLANES > 1) ? $clog2(MAX_PLANES) : 1;
   localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

   // Index of the last plane word of a group for a given planes-per-pixel mode.
   function automatic logic [PTR_W-1:0] last_plane(input logic [1:0] m);
      int p;
      case (m)
         2'd0:    p = 4;
         2'd1:    p = 2;
         default: p = 1;
      endcase
      if (p > MAX_PLANES) p = MAX_PLANES;
      return PTR_W'(p - 1);
   endfunction

   logic [WORD_W-1:0] latch    [MAX_PLANES];
   logic [WORD_W-1:0] shreg    [MAX_PLANES];
   logic [WORD_W-1:0] load_val [MAX_PLANES];
   logic [WORD_W-1:0] src_word;
   logic [PTR_W-1:0]  load_ptr;
   logic [1:0]        cur_mode;
   logic [1:0]        wr_mode;
   logic [1:0]        src_mode;
   logic              group_full;
   logic              line_active;
   logic [CNT_W-1:0]  pix_cntr;
   logic [CNT_W-1:0]  sc;
   logic              r_start;
   logic              r_wrap;
   logic              take_full;
   logic              accept;
   logic              complete;
   logic              grp_ready;
   logic              consume;
   logic              starve;

`ifdef SHIFTER_HSCROLL_EN
   assign sc = CNT_W'(hscroll);
`else
   logic unused_hscroll;
   assign unused_hscroll = ^hscroll;
   assign sc = '0;
`endif

   // A reload that consumes the full group frees the latches, so a LOAD on that same
   // edge is accepted as the first word of the following group.
   always_comb begin
      wr_mode   = (load_ptr == '0) ? mode : cur_mode;
      r_start   = pixClkEn & ~line_active & DE;
      r_wrap    = pixClkEn & line_active & (pix_cntr == CNT_LAST);
      take_full = group_full & (r_start | r_wrap);
      accept    = LOAD & (~group_full | take_full);
      complete  = accept & (load_ptr == last_plane(wr_mode));
      grp_ready = group_full | complete;
      consume   = grp_ready & (r_start | r_wrap);
      starve    = r_wrap & ~grp_ready & DE;
      src_mode  = group_full ? cur_mode : wr_mode;
      src_word  = '0;
      for (int i = 0; i < MAX_PLANES; i++) begin
         load_val[i] = '0;
         if (i <= int'(last_plane(src_mode))) begin
            src_word = latch[i];
            // A word completing the group on the reload edge is used straight from DIN.
            if (!group_full && LOAD && (load_ptr == PTR_W'(i))) src_word = DIN;
            load_val[i] = r_start ? (src_word << sc) : src_word;
         end
      end
   end

   always_ff @(posedge clk32 or negedge nReset) begin
      if (!nReset) begin
         for (int i = 0; i < MAX_PLANES; i++) begin
            latch[i] <= '0;
            shreg[i] <= '0;
         end
         load_ptr    <= '0;
         cur_mode    <= '0;
         group_full  <= 1'b0;
         line_active <= 1'b0;
         pix_cntr    <= '0;
         underrun    <= 1'b0;
      end else begin
         if (LOAD) latch[load_ptr] <= DIN;
         if (accept) begin
            if (load_ptr == '0) cur_mode <= mode;
            load_ptr <= complete ? '0 : load_ptr + PTR_W'(1);
         end
         group_full <= consume ? (group_full & complete) : (group_full | complete);
         if (pixClkEn) underrun <= starve;
         if (consume) begin
            for (int i = 0; i < MAX_PLANES; i++) shreg[i] <= load_val[i];
            pix_cntr    <= r_start ? sc : '0;
            line_active <= 1'b1;
         end else if (r_wrap) begin
            for (int i = 0; i < MAX_PLANES; i++) shreg[i] <= '0;
            pix_cntr <= '0;
            if (!DE) line_active <= 1'b0;
         end else if (pixClkEn && line_active) begin
            for (int i = 0; i < MAX_PLANES; i++) shreg[i] <= {shreg[i][WORD_W-2:0], 1'b0};
            pix_cntr <= pix_cntr + CNT_W'(1);
         end
      end
   end

   // Planes beyond the group's plane count were loaded with zero, so no masking is needed.
   always_comb begin
      for (int i = 0; i < MAX_PLANES; i++) color_index[i] = shreg[i][WORD_W-1];
   end

   assign pix_valid = line_active;

endmodule

// File: tb/tb_shifter_planar.sv
// tb_shifter_planar: directed and randomized checks of shifter_planar against a
// pixel-stream model computed from group words, plane mode and scroll.
module tb_shifter_planar;
   localparam int WORD_W     = 16;
   localparam int MAX_PLANES = 4;
   localparam int SC_W       = 4;
`ifdef SHIFTER_HSCROLL_EN
   localparam bit SCROLL_ON = 1'b1;
`else
   localparam bit SCROLL_ON = 1'b0;
`endif

   logic                  clk32;
   logic                  nReset;
   logic                  pixClkEn;
   logic                  DE;
   logic                  LOAD;
   logic [1:0]            mode;
   logic [WORD_W-1:0]     DIN;
   logic [SC_W-1:0]       hscroll;
   logic [MAX_PLANES-1:0] color_index;
   logic                  pix_valid;
   logic                  underrun;

   int checks = 0;
   int passed = 0;

   logic [WORD_W-1:0]     gw [4][4];
   logic [1:0]            gm [4];
   int                    line_sc;
   logic [MAX_PLANES-1:0] exp_q [$];

   shifter_planar #(.WORD_W(WORD_W), .MAX_PLANES(MAX_PLANES), .SC_W(SC_W)) dut (
      .clk32      (clk32),
      .nReset     (nReset),
      .pixClkEn   (pixClkEn),
      .DE         (DE),
      .LOAD       (LOAD),
      .mode       (mode),
      .DIN        (DIN),
      .hscroll    (hscroll),
      .color_index(color_index),
      .pix_valid  (pix_valid),
      .underrun   (underrun)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk32 = 1'b0;
      forever #5 clk32 = ~clk32;
   end

   // Pixel enable on every second clk32 edge.
   initial begin
      pixClkEn = 1'b0;
      forever begin
         @(posedge clk32);
         #1;
         pixClkEn = ~pixClkEn;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
      $fatal(1);
   end

   // ---------------- model ----------------
   function automatic int planes(input logic [1:0] m);
      return (m == 2'd0) ? 4 : ((m == 2'd1) ? 2 : 1);
   endfunction

   task automatic push_group(input int g, input int sc);
      logic [WORD_W-1:0]     w;
      logic [MAX_PLANES-1:0] idx;
      for (int j = 0; j < WORD_W - sc; j++) begin
         idx = '0;
         for (int k = 0; k < planes(gm[g]); k++) begin
            w = gw[g][k];
            idx[k] = w[WORD_W-1-sc-j];
         end
         exp_q.push_back(idx);
      end
   endtask

   task automatic rand_group(input int g);
      gm[g] = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) gw[g][k] = 16'($urandom);
   endtask

   // ---------------- drivers ----------------
   task automatic cyc();
      @(posedge clk32);
      #2;
   endtask

   task automatic load_word(input logic [WORD_W-1:0] w, input logic [1:0] m);
      LOAD = 1'b1;
      DIN  = w;
      mode = m;
      cyc();
      LOAD = 1'b0;
      DIN  = 16'($urandom);
      mode = 2'($urandom);
   endtask

   task automatic load_group(input int g);
      for (int i = 0; i < planes(gm[g]); i++)
         load_word(gw[g][i], (i == 0) ? gm[g] : 2'($urandom));
   endtask

   // Advance to just after the next pixel edge, optionally loading a word on that edge.
   task automatic pix_step(input bit do_load, input logic [WORD_W-1:0] w, input logic [1:0] m);
      if (pixClkEn !== 1'b1) cyc();
      if (do_load) begin
         LOAD = 1'b1;
         DIN  = w;
         mode = m;
      end
      cyc();
      LOAD = 1'b0;
      DIN  = 16'($urandom);
      mode = 2'($urandom);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      nReset  = 1'b0;
      DE      = 1'b0;
      LOAD    = 1'b0;
      DIN     = 16'($urandom);
      mode    = 2'($urandom);
      hscroll = 4'($urandom);
      repeat (3) cyc();
      checks++;
      if (color_index !== 4'd0) $display("FAIL reset_color: got %0h expected 0", color_index);
      else passed++;
      checks++;
      if (pix_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", pix_valid);
      else passed++;
      checks++;
      if (underrun !== 1'b0) $display("FAIL reset_underrun: got %0b expected 0", underrun);
      else passed++;
      nReset = 1'b1;
      repeat (4) cyc();
      checks++;
      if (pix_valid !== 1'b0) $display("FAIL idle_valid: got %0b expected 0", pix_valid);
      else passed++;
   endtask

   task automatic test_directed();
      hscroll = '0;
      DE = 1'b0;
      load_word(16'h8000, 2'd0);
      load_word(16'h0000, 2'($urandom));
      load_word(16'h8000, 2'($urandom));
      load_word(16'h0000, 2'($urandom));
      DE = 1'b1;
      for (int j = 0; j < WORD_W; j++) begin
         pix_step(1'b0, '0, '0);
         if (j == 0) DE = 1'b0;
         checks++;
         if (color_index !== ((j == 0) ? 4'd5 : 4'd0))
            $display("FAIL mode0_pixel: pixel %0d got %0h expected %0h", j, color_index, (j == 0) ? 5 : 0);
         else passed++;
         checks++;
         if (pix_valid !== 1'b1) $display("FAIL mode0_valid: pixel %0d got %0b expected 1", j, pix_valid);
         else passed++;
      end
      pix_step(1'b0, '0, '0);
      checks++;
      if (pix_valid !== 1'b0 || underrun !== 1'b0)
         $display("FAIL mode0_end: got valid=%0b underrun=%0b expected valid=0 underrun=0", pix_valid, underrun);
      else passed++;

      load_word(16'hFFFF, 2'd1);
      load_word(16'h0000, 2'($urandom));
      DE = 1'b1;
      for (int j = 0; j < WORD_W; j++) begin
         pix_step(1'b0, '0, '0);
         if (j == 0) DE = 1'b0;
         checks++;
         if (color_index !== 4'd1 || pix_valid !== 1'b1)
            $display("FAIL mode1_pixel: pixel %0d got idx=%0h valid=%0b expected idx=1 valid=1", j, color_index, pix_valid);
         else passed++;
      end
      pix_step(1'b0, '0, '0);
      checks++;
      if (pix_valid !== 1'b0) $display("FAIL mode1_end: got %0b expected 0", pix_valid);
      else passed++;
   endtask

   task automatic test_hscroll();
      int sc_eff;
      int n;
      sc_eff = SCROLL_ON ? 5 : 0;
      n = WORD_W - sc_eff;
      DE = 1'b0;
      hscroll = 4'd5;
      load_word(16'h0400, 2'd2);
      DE = 1'b1;
      for (int j = 0; j < n; j++) begin
         pix_step(1'b0, '0, '0);
         if (j == 0) begin
            DE = 1'b0;
            hscroll = 4'($urandom);
         end
         checks++;
         if (color_index !== ((j == 5 - sc_eff) ? 4'd1 : 4'd0) || pix_valid !== 1'b1)
            $display("FAIL scroll_pixel: pixel %0d got idx=%0h valid=%0b expected idx=%0h valid=1",
                     j, color_index, pix_valid, (j == 5 - sc_eff) ? 1 : 0);
         else passed++;
      end
      pix_step(1'b0, '0, '0);
      checks++;
      if (pix_valid !== 1'b0) $display("FAIL scroll_group_len: got valid=%0b expected 0", pix_valid);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int n;
      logic [MAX_PLANES-1:0] e;
      for (int iter = 0; iter < 4; iter++) begin
         for (int g = 0; g < 4; g++) rand_group(g);
         line_sc = SCROLL_ON ? $urandom_range(0, 11) : 0;
         hscroll = SCROLL_ON ? 4'(line_sc) : 4'($urandom);
         exp_q.delete();
         push_group(0, line_sc);
         for (int g = 1; g < 4; g++) push_group(g, 0);
         DE = 1'b0;
         load_group(0);
         DE = 1'b1;
         for (int g = 0; g < 4; g++) begin
            n = (g == 0) ? WORD_W - line_sc : WORD_W;
            for (int j = 0; j < n; j++) begin
               if (j == 0 && g == 1)
                  pix_step(1'b1, gw[1][planes(gm[1]) - 1], (planes(gm[1]) == 1) ? gm[1] : 2'($urandom));
               else if (j == 0 && g == 2)
                  pix_step(1'b1, gw[3][0], gm[3]);
               else begin
                  if (g == 0 && j >= 1 && j <= planes(gm[1]) - 1)
                     load_word(gw[1][j-1], (j == 1) ? gm[1] : 2'($urandom));
                  if (g == 1 && j >= 1 && j <= planes(gm[2]))
                     load_word(gw[2][j-1], (j == 1) ? gm[2] : 2'($urandom));
                  if (g == 2 && j >= 1 && j <= planes(gm[3]) - 1)
                     load_word(gw[3][j], 2'($urandom));
                  pix_step(1'b0, '0, '0);
               end
               if (g == 3 && j == 0) DE = 1'b0;
               e = exp_q.pop_front();
               checks++;
               if (color_index !== e)
                  $display("FAIL b2b_pixel: iter %0d group %0d pixel %0d got %0h expected %0h", iter, g, j, color_index, e);
               else passed++;
               checks++;
               if (pix_valid !== 1'b1 || underrun !== 1'b0)
                  $display("FAIL b2b_flags: iter %0d group %0d pixel %0d got valid=%0b underrun=%0b expected 1/0",
                           iter, g, j, pix_valid, underrun);
               else passed++;
            end
         end
         pix_step(1'b0, '0, '0);
         checks++;
         if (pix_valid !== 1'b0 || underrun !== 1'b0 || color_index !== 4'd0)
            $display("FAIL b2b_end: iter %0d got valid=%0b underrun=%0b idx=%0h expected 0/0/0",
                     iter, pix_valid, underrun, color_index);
         else passed++;
      end
   endtask

   task automatic test_underrun();
      logic [MAX_PLANES-1:0] e;
      rand_group(0);
      hscroll = '0;
      exp_q.delete();
      push_group(0, 0);
      DE = 1'b0;
      load_group(0);
      DE = 1'b1;
      for (int j = 0; j < WORD_W; j++) begin
         pix_step(1'b0, '0, '0);
         e = exp_q.pop_front();
         checks++;
         if (color_index !== e || underrun !== 1'b0)
            $display("FAIL ur_first_group: pixel %0d got idx=%0h underrun=%0b expected idx=%0h underrun=0",
                     j, color_index, underrun, e);
         else passed++;
      end
      pix_step(1'b0, '0, '0);
      checks++;
      if (underrun !== 1'b1 || pix_valid !== 1'b1 || color_index !== 4'd0)
         $display("FAIL ur_pulse: got underrun=%0b valid=%0b idx=%0h expected 1/1/0", underrun, pix_valid, color_index);
      else passed++;
      for (int j = 1; j < WORD_W; j++) begin
         pix_step(1'b0, '0, '0);
         if (j == 1) DE = 1'b0;
         checks++;
         if (underrun !== 1'b0 || pix_valid !== 1'b1 || color_index !== 4'd0)
            $display("FAIL ur_black: pixel %0d got underrun=%0b valid=%0b idx=%0h expected 0/1/0",
                     j, underrun, pix_valid, color_index);
         else passed++;
      end
      pix_step(1'b0, '0, '0);
      checks++;
      if (pix_valid !== 1'b0 || underrun !== 1'b0)
         $display("FAIL ur_end: got valid=%0b underrun=%0b expected 0/0", pix_valid, underrun);
      else passed++;
   endtask

   task automatic test_reset_mid();
      logic [MAX_PLANES-1:0] e;
      rand_group(0);
      gm[0] = 2'd0;
      hscroll = '0;
      exp_q.delete();
      push_group(0, 0);
      DE = 1'b0;
      load_group(0);
      DE = 1'b1;
      for (int j = 0; j < 5; j++) begin
         pix_step(1'b0, '0, '0);
         e = exp_q.pop_front();
         checks++;
         if (color_index !== e) $display("FAIL rst_pre: pixel %0d got %0h expected %0h", j, color_index, e);
         else passed++;
      end
      load_word(16'($urandom), 2'd0);
      load_word(16'($urandom), 2'($urandom));
      nReset = 1'b0;
      #1;
      checks++;
      if (color_index !== 4'd0 || pix_valid !== 1'b0 || underrun !== 1'b0)
         $display("FAIL rst_async: got idx=%0h valid=%0b underrun=%0b expected 0/0/0", color_index, pix_valid, underrun);
      else passed++;
      cyc();
      nReset = 1'b1;
      for (int j = 0; j < 4; j++) begin
         pix_step(1'b0, '0, '0);
         checks++;
         if (pix_valid !== 1'b0 || underrun !== 1'b0)
            $display("FAIL rst_idle: step %0d got valid=%0b underrun=%0b expected 0/0", j, pix_valid, underrun);
         else passed++;
      end
      rand_group(0);
      gm[0] = 2'd0;
      exp_q.delete();
      push_group(0, 0);
      DE = 1'b0;
      load_group(0);
      DE = 1'b1;
      for (int j = 0; j < WORD_W; j++) begin
         pix_step(1'b0, '0, '0);
         if (j == 0) DE = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if (color_index !== e || pix_valid !== 1'b1)
            $display("FAIL rst_restart: pixel %0d got idx=%0h valid=%0b expected idx=%0h valid=1", j, color_index, pix_valid, e);
         else passed++;
      end
      pix_step(1'b0, '0, '0);
      checks++;
      if (pix_valid !== 1'b0) $display("FAIL rst_end: got %0b expected 0", pix_valid);
      else passed++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      nReset  = 1'b0;
      DE      = 1'b0;
      LOAD    = 1'b0;
      mode    = '0;
      DIN     = '0;
      hscroll = '0;
      test_reset();
      test_directed();
      test_hscroll();
      test_back_to_back();
      test_underrun();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
